uart_cfg_sequencer: RTL and testbench
=====================================

UART_CFG_SEQUENCER -- requirements
Module: uart_cfg_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 5, meaning the maximum number of cycles stb_o stays high without ack before abort (legal 1..255).
REQ-002 SHALL have parameter DIV_W, default 16, meaning the divisor width (fixed at 16, two latch bytes).
REQ-003 SHALL have one clock and an asynchronous active-low reset: wb_clk_i  in  1  clock; wb_rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  in  1  pulse requesting a configuration run.
REQ-005 SHALL have port divisor_i  in  DIV_W  baud divisor (sysclk/(16*baud)).
REQ-006 SHALL have ports lcr_i, fcr_i and ier_i  in  8 each  line-control, FIFO-control and interrupt-enable values (lcr_i[7] ignored).
REQ-007 SHALL have Wishbone master ports: wb_adr_o  out  3  address; wb_dat_o  out  8  write data; wb_dat_i  in  8  read data (unused); wb_we_o  out  1  write enable; wb_stb_o  out  1  strobe; wb_cyc_o  out  1  cycle; wb_sel_o  out  4  byte select; wb_ack_i  in  1  acknowledge.
REQ-008 SHALL have status ports: busy_o  out  1  run in progress; done_o  out  1  one-cycle success pulse; err_o  out  1  sticky timeout flag; err_step_o  out  3  index of the aborted write.

Function
REQ-009 SHALL implement states IDLE, ISSUE, GAP, DONE and ERR; all outputs SHALL be registered.
REQ-010 SHALL accept start_i only in IDLE, latch divisor_i, lcr_i, fcr_i and ier_i, clear err_o and err_step_o, and enter ISSUE with step=0.
REQ-011 SHALL ignore start_i in ISSUE, GAP, DONE and ERR.
REQ-012 SHALL issue six writes in order: step0 adr 3 = lcr|0x80; step1 adr 1 = div[15:8]; step2 adr 0 = div[7:0]; step3 adr 3 = lcr&0x7F; step4 adr 2 = fcr; step5 adr 1 = ier.
REQ-013 SHALL, in ISSUE, drive cyc_o=stb_o=we_o=1 and sel_o=4'b0001, holding adr_o and dat_o stable until ack_i is sampled high.
REQ-014 SHALL, on sampling ack_i=1 in ISSUE, deassert cyc_o and stb_o in the next cycle and enter GAP (steps 0-4) or DONE (step 5).
REQ-015 SHALL spend exactly one cycle in GAP with cyc_o=0, increment step, then return to ISSUE.
REQ-016 SHALL count ISSUE cycles without ack; when the count reaches ACK_TIMEOUT, it SHALL deassert cyc_o and stb_o, set err_o=1 and err_step_o=step, and enter ERR.
REQ-017 SHALL give ack precedence over timeout when ack_i is sampled high in the cycle the count reaches ACK_TIMEOUT.
REQ-018 SHALL restart the timeout counter at 0 for every write.
REQ-019 SHALL ignore ack_i outside ISSUE.
REQ-020 SHALL assert done_o for exactly one cycle in DONE, then go to IDLE.
REQ-021 SHALL stay in ERR for one cycle, then go to IDLE; err_o SHALL stay set until the next accepted start_i.
REQ-022 SHALL assert busy_o in ISSUE, GAP, DONE and ERR, and deassert it in IDLE.
REQ-023 SHALL drive sel_o=4'b0000, we_o=0 and adr_o/dat_o=0 whenever cyc_o=0.
REQ-024 SHALL write divisor value 0 like any other value, with no special case.

Reset
REQ-025 SHALL, on wb_rstn_i=0, immediately (asynchronously) force IDLE, step=0, timeout count=0, and all outputs to 0, including cyc_o and stb_o during a transfer.
REQ-026 SHALL start in IDLE after reset release, with no write issued until start_i.

Verification
REQ-027 Slave that acks one cycle after stb, start at cycle 0 with div=0x0088, lcr=0x03, fcr=0xC7, ier=0x01 -> writes (3,0x83),(1,0x00),(0,0x88),(3,0x03),(2,0xC7),(1,0x01), stb_o in cycles 1,4,7,10,13,16, done_o in cycle 18, busy_o low from cycle 19.
REQ-028 Slave that never acks on step2 -> stb_o high exactly 5 cycles, then low, err_o=1, err_step_o=2, no further writes, done_o never asserted.
REQ-029 Ack arriving in the fifth stalled ISSUE cycle (ACK_TIMEOUT=5) -> write completes, err_o stays 0, run finishes normally.
REQ-030 start_i pulsed repeatedly while busy_o=1 -> exactly six writes and a single done_o pulse.
REQ-031 wb_rstn_i asserted while stb_o=1 on step3 -> cyc_o/stb_o drop in the same cycle, all outputs 0, and a new start runs from step0.
REQ-032 Start after an errored run -> err_o clears on acceptance and the full six-write sequence completes.

Source files
------------

// File: rtl/uart_cfg_sequencer.sv
// Wishbone master that programs a 16550-style UART: DLAB on, divisor hi/lo, DLAB off, FCR, IER.
// Each write holds until ack; a stalled write aborts after ACK_TIMEOUT strobe cycles.
module uart_cfg_sequencer #(
    parameter int ACK_TIMEOUT = 5,
    parameter int DIV_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] divisor_i,
    input  logic [7:0]       lcr_i,
    input  logic [7:0]       fcr_i,
    input  logic [7:0]       ier_i,
    output logic [2:0]       wb_adr_o,
    output logic [7:0]       wb_dat_o,
    input  logic [7:0]       wb_dat_i,
    output logic             wb_we_o,
    output logic             wb_stb_o,
    output logic             wb_cyc_o,
    output logic [3:0]       wb_sel_o,
    input  logic             wb_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       err_step_o
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE, S_ERR} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [2:0] LAST_STEP = 3'd5;

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [6:0]       lcr_q, lcr_d;
    logic [7:0]       fcr_q, fcr_d;
    logic [7:0]       ier_q, ier_d;

    logic             wr_d;
    logic [2:0]       adr_d;
    logic [7:0]       dat_d;
    logic             err_d;
    logic [2:0]       err_step_d;

    // Read data and the DLAB bit of lcr_i are never consumed.
    logic unused_in;
    assign unused_in = ^{wb_dat_i, lcr_i[7]};

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            tmo_q   <= '0;
            div_q   <= '0;
            lcr_q   <= '0;
            fcr_q   <= '0;
            ier_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tmo_q   <= tmo_d;
            div_q   <= div_d;
            lcr_q   <= lcr_d;
            fcr_q   <= fcr_d;
            ier_q   <= ier_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tmo_d   = tmo_q;
        div_d   = div_q;
        lcr_d   = lcr_q;
        fcr_d   = fcr_q;
        ier_d   = ier_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    step_d  = '0;
                    tmo_d   = '0;
                    div_d   = divisor_i;
                    lcr_d   = lcr_i[6:0];
                    fcr_d   = fcr_i;
                    ier_d   = ier_i;
                end
            end
            S_ISSUE: begin
                // ack wins even in the cycle the timeout would fire
                if (wb_ack_i) begin
                    tmo_d   = '0;
                    state_d = (step_q == LAST_STEP) ? S_DONE : S_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_GAP: begin
                step_d  = step_q + 3'd1;
                state_d = S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight out of flops.
    always_comb begin
        wr_d       = (state_d == S_ISSUE);
        adr_d      = '0;
        dat_d      = '0;
        err_d      = err_o;
        err_step_d = err_step_o;
        if (wr_d) begin
            case (step_d)
                3'd0:    begin adr_d = 3'd3; dat_d = {1'b1, lcr_d}; end
                3'd1:    begin adr_d = 3'd1; dat_d = div_d[15:8]; end
                3'd2:    begin adr_d = 3'd0; dat_d = div_d[7:0]; end
                3'd3:    begin adr_d = 3'd3; dat_d = {1'b0, lcr_d}; end
                3'd4:    begin adr_d = 3'd2; dat_d = fcr_d; end
                default: begin adr_d = 3'd1; dat_d = ier_d; end
            endcase
        end
        if (state_q == S_IDLE && start_i) begin
            err_d      = 1'b0;
            err_step_d = '0;
        end else if (state_q == S_ISSUE && state_d == S_ERR) begin
            err_d      = 1'b1;
            err_step_d = step_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_sel_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_step_o <= '0;
        end else begin
            wb_adr_o   <= adr_d;
            wb_dat_o   <= dat_d;
            wb_we_o    <= wr_d;
            wb_stb_o   <= wr_d;
            wb_cyc_o   <= wr_d;
            wb_sel_o   <= {3'b000, wr_d};
            busy_o     <= (state_d != S_IDLE);
            done_o     <= (state_d == S_DONE);
            err_o      <= err_d;
            err_step_o <= err_step_d;
        end
    end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Randomized bench for uart_cfg_sequencer: an in-bench Wishbone slave with per-write ack delays,
// checked against the expected write list, run length, done/err outcome computed from the rules.
module tb_uart_cfg_sequencer;

    localparam int ACK_TO = 5;
    localparam int NEVER  = 99;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] divisor_i = '0;
    logic [7:0]  lcr_i = '0, fcr_i = '0, ier_i = '0;
    logic [2:0]  wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i = '0;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_step_o;

    int n_checks = 0;
    int n_fail   = 0;
    int dly[6];

    uart_cfg_sequencer #(.ACK_TIMEOUT(ACK_TO), .DIV_W(16)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .start_i(start_i), .divisor_i(divisor_i),
        .lcr_i(lcr_i), .fcr_i(fcr_i), .ier_i(ier_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_step_o(err_step_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bus_violation();
        if (wb_cyc_o !== wb_stb_o || wb_we_o !== wb_stb_o) return 1;
        if (wb_sel_o !== (wb_stb_o ? 4'b0001 : 4'b0000)) return 1;
        if (!wb_cyc_o && (wb_adr_o !== 3'd0 || wb_dat_o !== 8'd0)) return 1;
        return 0;
    endfunction

    // One configuration run; dly[i] is the ISSUE cycle (1-based) in which write i is acked.
    task automatic do_run(input logic [15:0] dv, input logic [7:0] l, input logic [7:0] f,
                          input logic [7:0] ie, input bit spam);
        logic [2:0] exp_adr[6];
        logic [7:0] exp_dat[6];
        int abort_step, exp_nwr, exp_busy;
        int nwr, stb_run, busy_cnt, done_cnt, done_at, proto;
        bit finished;
        exp_adr = '{3'd3, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1};
        exp_dat = '{l | 8'h80, dv[15:8], dv[7:0], l & 8'h7F, f, ie};
        abort_step = -1;
        exp_busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (dly[i] > ACK_TO) begin
                abort_step = i;
                exp_busy += ACK_TO + 1;
                break;
            end
            exp_busy += dly[i] + 1;
        end
        exp_nwr = (abort_step < 0) ? 6 : abort_step;

        divisor_i = dv; lcr_i = l; fcr_i = f; ier_i = ie;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        nwr = 0; stb_run = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; proto = 0;
        finished = 0;
        for (int c = 1; c <= 300; c++) begin
            if (c == 1) check_eq("err_clear_on_start", {31'd0, err_o}, 32'd0);
            if (!busy_o) begin
                finished = 1;
                break;
            end
            busy_cnt++;
            proto += bus_violation();
            if (done_o) begin
                done_cnt++;
                done_at = c;
            end
            if (wb_stb_o) begin
                stb_run++;
                wb_ack_i = (nwr < 6) && (stb_run == dly[nwr]);
                if (wb_ack_i) begin
                    check_eq($sformatf("adr_w%0d", nwr), {29'd0, wb_adr_o}, {29'd0, exp_adr[nwr]});
                    check_eq($sformatf("dat_w%0d", nwr), {24'd0, wb_dat_o}, {24'd0, exp_dat[nwr]});
                    nwr++;
                end
            end else begin
                stb_run = 0;
                wb_ack_i = ($urandom_range(0, 3) == 0);
            end
            start_i = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start_i = 1'b0;
        wb_ack_i = 1'b0;
        check_eq("run_terminates", {31'd0, finished}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            proto += bus_violation();
            if (wb_stb_o || busy_o) proto++;
            tick();
        end
        check_eq("bus_protocol", proto, 0);
        check_eq("write_count", nwr, exp_nwr);
        check_eq("busy_cycles", busy_cnt, exp_busy);
        check_eq("done_pulses", done_cnt, (abort_step < 0) ? 1 : 0);
        if (abort_step < 0) check_eq("done_cycle", done_at, exp_busy);
        check_eq("err_flag", {31'd0, err_o}, (abort_step < 0) ? 32'd0 : 32'd1);
        if (abort_step >= 0) check_eq("err_step", {29'd0, err_step_o}, abort_step);
    endtask

    initial begin
        int stb_run, nwr;
        #1;
        check_eq("reset_outputs",
                 {wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o, busy_o, done_o, err_o, err_step_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("idle_after_reset", {busy_o, wb_stb_o, wb_cyc_o}, 0);

        // Nominal run: ack one cycle after strobe rises.
        for (int i = 0; i < 6; i++) dly[i] = 2;
        do_run(16'h0088, 8'h03, 8'hC7, 8'h01, 0);

        // Slave stalls forever on step 2.
        dly = '{2, 2, NEVER, 2, 2, 2};
        do_run(16'h1234, 8'h1B, 8'h07, 8'h0F, 0);

        // Every ack lands in the last permitted cycle; also follows an errored run.
        for (int i = 0; i < 6; i++) dly[i] = ACK_TO;
        do_run(16'h0000, 8'h83, 8'h00, 8'h00, 0);

        // Start spammed while busy.
        for (int i = 0; i < 6; i++) dly[i] = 1;
        do_run(16'hFFFF, 8'h7F, 8'hFF, 8'hFF, 1);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 6; i++) dly[i] = $urandom_range(1, ACK_TO);
            if ($urandom_range(0, 4) == 0) dly[$urandom_range(0, 5)] = NEVER;
            do_run(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset asserted mid-write on step 3.
        for (int i = 0; i < 6; i++) dly[i] = 2;
        divisor_i = 16'hABCD; lcr_i = 8'h03; fcr_i = 8'h01; ier_i = 8'h02;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        stb_run = 0; nwr = 0;
        for (int c = 0; c < 100; c++) begin
            if (wb_stb_o && nwr == 3) break;
            if (wb_stb_o) begin
                stb_run++;
                wb_ack_i = (stb_run == 2);
                if (wb_ack_i) nwr++;
            end else begin
                stb_run = 0;
                wb_ack_i = 1'b0;
            end
            tick();
        end
        check_eq("reached_step3", {31'd0, wb_stb_o}, 32'd1);
        wb_ack_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o, busy_o, done_o, err_o, err_step_o}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        do_run(16'h0188, 8'h03, 8'hC7, 8'h05, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
